// File: rtl/llr_stream_extremum.sv
// rtl/llr_stream_extremum.sv - streaming signed max/min (+ optional second-min, macro SECOND_MIN_EN) with element indices per frame
module llr_stream_extremum #(
    parameter  int LLR_BIT   = 6,
    parameter  int LANES     = 3,
    parameter  int FRAME_LEN = 8,
    localparam int IDX_BIT   = (LANES * FRAME_LEN > 1) ? $clog2(LANES * FRAME_LEN) : 1
) (
    input  logic                       clk,
    input  logic                       rst_n,
    input  logic                       in_valid,
    output logic                       in_ready,
    input  logic [LANES*LLR_BIT-1:0]   in_llr,
    output logic                       out_valid,
    input  logic                       out_ready,
    output logic signed [LLR_BIT-1:0]  out_max,
    output logic signed [LLR_BIT-1:0]  out_min,
    output logic [IDX_BIT-1:0]         out_max_idx,
    output logic [IDX_BIT-1:0]         out_min_idx
`ifdef SECOND_MIN_EN
    ,
    output logic signed [LLR_BIT-1:0]  out_min2
`endif
);

    localparam int LANE_BIT = (LANES > 1) ? $clog2(LANES) : 1;
    localparam int CNT_BIT  = (FRAME_LEN > 1) ? $clog2(FRAME_LEN) : 1;
    // Lane count rounded up to a power of two so the reduction tree is complete
    localparam int NPAD     = 1 << $clog2(LANES);
    localparam logic [CNT_BIT-1:0] LAST_BEAT = CNT_BIT'(FRAME_LEN - 1);
`ifdef SECOND_MIN_EN
    localparam logic signed [LLR_BIT-1:0] SAT_MAX = {1'b0, {(LLR_BIT-1){1'b1}}};
`endif

    // Beat bookkeeping
    logic [CNT_BIT-1:0]         beat_cnt;
    logic                       accept;
    logic                       first_beat;
    logic                       last_beat;
    logic [IDX_BIT-1:0]         beat_base;

    // Running accumulators for the frame in progress
    logic signed [LLR_BIT-1:0]  acc_max;
    logic signed [LLR_BIT-1:0]  acc_min;
    logic [IDX_BIT-1:0]         acc_max_idx;
    logic [IDX_BIT-1:0]         acc_min_idx;

    // Lane values, padded with inert entries up to NPAD
    logic signed [LLR_BIT-1:0]  lane_llr [NPAD];

    // Reduction tree, heap layout: node i has children 2i and 2i+1, leaves at NPAD..2*NPAD-1
    logic signed [LLR_BIT-1:0]  t_max      [1:2*NPAD-1];
    logic signed [LLR_BIT-1:0]  t_min      [1:2*NPAD-1];
    logic [LANE_BIT-1:0]        t_max_lane [1:2*NPAD-1];
    logic [LANE_BIT-1:0]        t_min_lane [1:2*NPAD-1];
    logic                       t_vld      [1:2*NPAD-1];

    // Beat reduction and merged (next) values
    logic signed [LLR_BIT-1:0]  beat_max;
    logic signed [LLR_BIT-1:0]  beat_min;
    logic [IDX_BIT-1:0]         beat_max_idx;
    logic [IDX_BIT-1:0]         beat_min_idx;
    logic signed [LLR_BIT-1:0]  nxt_max;
    logic signed [LLR_BIT-1:0]  nxt_min;
    logic [IDX_BIT-1:0]         nxt_max_idx;
    logic [IDX_BIT-1:0]         nxt_min_idx;

`ifdef SECOND_MIN_EN
    logic signed [LLR_BIT-1:0]  acc_min2;
    logic signed [LLR_BIT-1:0]  nxt_min2;
    logic signed [LLR_BIT-1:0]  m1;
    logic signed [LLR_BIT-1:0]  m2;
`endif

    assign in_ready   = ~out_valid | out_ready;
    assign accept     = in_valid & in_ready;
    assign first_beat = (beat_cnt == '0);
    assign last_beat  = (beat_cnt == LAST_BEAT);
    assign beat_base  = IDX_BIT'(beat_cnt) * IDX_BIT'(LANES);

    for (genvar k = 0; k < NPAD; k++) begin : g_lane
        if (k < LANES) begin : g_real
            assign lane_llr[k] = in_llr[k*LLR_BIT +: LLR_BIT];
        end else begin : g_pad
            assign lane_llr[k] = '0;
        end
    end

    // Lane reduction tree; the left (lower-index) child wins unless the right one is strictly better
    always_comb begin
        for (int k = 0; k < NPAD; k++) begin
            t_max[NPAD+k]      = lane_llr[k];
            t_min[NPAD+k]      = lane_llr[k];
            t_max_lane[NPAD+k] = LANE_BIT'(k);
            t_min_lane[NPAD+k] = LANE_BIT'(k);
            t_vld[NPAD+k]      = (k < LANES);
        end
        for (int i = NPAD - 1; i >= 1; i--) begin
            // valid leaves form a prefix, so a valid right child implies a valid left child
            t_vld[i] = t_vld[2*i];
            if (t_vld[2*i+1] && (t_max[2*i+1] > t_max[2*i])) begin
                t_max[i]      = t_max[2*i+1];
                t_max_lane[i] = t_max_lane[2*i+1];
            end else begin
                t_max[i]      = t_max[2*i];
                t_max_lane[i] = t_max_lane[2*i];
            end
            if (t_vld[2*i+1] && (t_min[2*i+1] < t_min[2*i])) begin
                t_min[i]      = t_min[2*i+1];
                t_min_lane[i] = t_min_lane[2*i+1];
            end else begin
                t_min[i]      = t_min[2*i];
                t_min_lane[i] = t_min_lane[2*i];
            end
        end
    end

    assign beat_max     = t_max[1];
    assign beat_min     = t_min[1];
    assign beat_max_idx = beat_base + IDX_BIT'(t_max_lane[1]);
    assign beat_min_idx = beat_base + IDX_BIT'(t_min_lane[1]);

    // Merge beat reduction into the accumulator; later beats only replace on strict improvement
    always_comb begin
        nxt_max     = beat_max;
        nxt_max_idx = beat_max_idx;
        nxt_min     = beat_min;
        nxt_min_idx = beat_min_idx;
        if (!first_beat && !(beat_max > acc_max)) begin
            nxt_max     = acc_max;
            nxt_max_idx = acc_max_idx;
        end
        if (!first_beat && !(beat_min < acc_min)) begin
            nxt_min     = acc_min;
            nxt_min_idx = acc_min_idx;
        end
    end

`ifdef SECOND_MIN_EN
    // Insert each lane into the (min, second-min) pair; equal minima push the duplicate into second place
    always_comb begin
        m1 = first_beat ? SAT_MAX : acc_min;
        m2 = first_beat ? SAT_MAX : acc_min2;
        for (int k = 0; k < LANES; k++) begin
            if (lane_llr[k] < m1) begin
                m2 = m1;
                m1 = lane_llr[k];
            end else if (lane_llr[k] < m2) begin
                m2 = lane_llr[k];
            end
        end
        nxt_min2 = m2;
    end
`endif

    // Beat counter and running accumulators, advanced on every accepted beat
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            beat_cnt    <= '0;
            acc_max     <= '0;
            acc_min     <= '0;
            acc_max_idx <= '0;
            acc_min_idx <= '0;
`ifdef SECOND_MIN_EN
            acc_min2    <= '0;
`endif
        end else if (accept) begin
            beat_cnt    <= last_beat ? '0 : beat_cnt + 1'b1;
            acc_max     <= nxt_max;
            acc_min     <= nxt_min;
            acc_max_idx <= nxt_max_idx;
            acc_min_idx <= nxt_min_idx;
`ifdef SECOND_MIN_EN
            acc_min2    <= nxt_min2;
`endif
        end
    end

    // Result registers: load on the last-beat handshake, hold until popped
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            out_valid   <= 1'b0;
            out_max     <= '0;
            out_min     <= '0;
            out_max_idx <= '0;
            out_min_idx <= '0;
`ifdef SECOND_MIN_EN
            out_min2    <= '0;
`endif
        end else if (accept && last_beat) begin
            out_valid   <= 1'b1;
            out_max     <= nxt_max;
            out_min     <= nxt_min;
            out_max_idx <= nxt_max_idx;
            out_min_idx <= nxt_min_idx;
`ifdef SECOND_MIN_EN
            out_min2    <= nxt_min2;
`endif
        end else if (out_ready) begin
            out_valid   <= 1'b0;
        end
    end

endmodule

// File: tb/tb_llr_stream_extremum.sv
// tb/tb_llr_stream_extremum.sv - scoreboard bench for llr_stream_extremum (FRAME_LEN=2 and FRAME_LEN=1 instances)
module tb_llr_stream_extremum;

    localparam int L  = 6;
    localparam int N  = 3;
    localparam int IB0 = 3;   // index width for 3 lanes x 2 beats
    localparam int IB1 = 2;   // index width for 3 lanes x 1 beat

    typedef struct {
        int mx;
        int mxi;
        int mn;
        int mni;
        int mn2;
    } exp_t;

    logic clk = 1'b0;
    logic rst_n = 1'b0;

    logic                 in_valid0 = 1'b0, in_ready0, out_valid0, out_ready0 = 1'b1;
    logic [N*L-1:0]       in_llr0 = '0;
    logic signed [L-1:0]  out_max0, out_min0, out_min2_0;
    logic [IB0-1:0]       out_max_idx0, out_min_idx0;

    logic                 in_valid1 = 1'b0, in_ready1, out_valid1, out_ready1 = 1'b1;
    logic [N*L-1:0]       in_llr1 = '0;
    logic signed [L-1:0]  out_max1, out_min1, out_min2_1;
    logic [IB1-1:0]       out_max_idx1, out_min_idx1;

    int   nvec = 0;
    int   nfail = 0;
    bit   rdy_rand0 = 1'b0;
    bit   rdy_rand1 = 1'b0;
    exp_t q0[$];
    exp_t q1[$];
    exp_t e0, e1;

    always #5 clk = ~clk;

    llr_stream_extremum #(.LLR_BIT(L), .LANES(N), .FRAME_LEN(2)) dut0 (
        .clk(clk), .rst_n(rst_n),
        .in_valid(in_valid0), .in_ready(in_ready0), .in_llr(in_llr0),
        .out_valid(out_valid0), .out_ready(out_ready0),
        .out_max(out_max0), .out_min(out_min0),
        .out_max_idx(out_max_idx0), .out_min_idx(out_min_idx0)
`ifdef SECOND_MIN_EN
        , .out_min2(out_min2_0)
`endif
    );

    llr_stream_extremum #(.LLR_BIT(L), .LANES(N), .FRAME_LEN(1)) dut1 (
        .clk(clk), .rst_n(rst_n),
        .in_valid(in_valid1), .in_ready(in_ready1), .in_llr(in_llr1),
        .out_valid(out_valid1), .out_ready(out_ready1),
        .out_max(out_max1), .out_min(out_min1),
        .out_max_idx(out_max_idx1), .out_min_idx(out_min_idx1)
`ifdef SECOND_MIN_EN
        , .out_min2(out_min2_1)
`endif
    );

`ifndef SECOND_MIN_EN
    assign out_min2_0 = '0;
    assign out_min2_1 = '0;
`endif

    task automatic cmp(input string name, input int act, input int exp);
        nvec++;
        if (act != exp) begin
            nfail++;
            $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Reference: scan in element order with strict improvement; second-min from a sorted copy
    function automatic exp_t model(input int v[$]);
        exp_t e;
        int s[$];
        e.mx = v[0]; e.mxi = 0; e.mn = v[0]; e.mni = 0;
        for (int i = 1; i < v.size(); i++) begin
            if (v[i] > e.mx) begin e.mx = v[i]; e.mxi = i; end
            if (v[i] < e.mn) begin e.mn = v[i]; e.mni = i; end
        end
        s = v;
        s.sort();
        e.mn2 = (s.size() > 1) ? s[1] : (2 ** (L - 1)) - 1;
        return e;
    endfunction

    function automatic logic [N*L-1:0] pack(input int a, input int b, input int c);
        logic [L-1:0] la, lb, lc;
        la = L'(a); lb = L'(b); lc = L'(c);
        return {lc, lb, la};
    endfunction

    function automatic int rnd_llr(input bit narrow);
        if (narrow) return int'($urandom_range(0, 2)) - 1;
        return int'($urandom_range(0, 63)) - 32;
    endfunction

    // Called at posedge+1; returns at posedge+1 after the accepting edge
    task automatic beat0(input logic [N*L-1:0] d);
        int n;
        bit ok;
        in_valid0 = 1'b1; in_llr0 = d; n = 0; ok = 1'b0;
        while (!ok && n < 200) begin
            @(negedge clk); ok = in_ready0;
            @(posedge clk); n++;
        end
        #1 in_valid0 = 1'b0;
        if (!ok) cmp("dut0_beat_accept_timeout", 0, 1);
    endtask

    task automatic beat1(input logic [N*L-1:0] d);
        int n;
        bit ok;
        in_valid1 = 1'b1; in_llr1 = d; n = 0; ok = 1'b0;
        while (!ok && n < 200) begin
            @(negedge clk); ok = in_ready1;
            @(posedge clk); n++;
        end
        #1 in_valid1 = 1'b0;
        if (!ok) cmp("dut1_beat_accept_timeout", 0, 1);
    endtask

    task automatic frame0(input int v[6], input int gap);
        int q[$];
        foreach (v[i]) q.push_back(v[i]);
        for (int b = 0; b < 2; b++) begin
            beat0(pack(v[3*b], v[3*b+1], v[3*b+2]));
            if (b == 1) q0.push_back(model(q));
            repeat (gap) begin @(posedge clk); #1; end
        end
    endtask

    task automatic frame1(input int v[3], input int gap);
        int q[$];
        foreach (v[i]) q.push_back(v[i]);
        beat1(pack(v[0], v[1], v[2]));
        q1.push_back(model(q));
        repeat (gap) begin @(posedge clk); #1; end
    endtask

    task automatic drain();
        int n;
        n = 0;
        while ((q0.size() != 0 || q1.size() != 0) && n < 400) begin
            @(posedge clk); n++;
        end
        #1;
        cmp("drain_q0_empty", q0.size(), 0);
        cmp("drain_q1_empty", q1.size(), 0);
    endtask

    // Random backpressure when enabled
    always @(posedge clk) begin
        #1;
        if (rdy_rand0) out_ready0 = ($urandom_range(0, 3) != 0);
        if (rdy_rand1) out_ready1 = ($urandom_range(0, 2) != 0);
    end

    // Monitor dut0: compare presented result against scoreboard head; pop on handshake
    always @(negedge clk) begin
        if (rst_n && out_valid0) begin
            if (q0.size() == 0) begin
                cmp("dut0_unexpected_result", 1, 0);
            end else begin
                e0 = q0[0];
                cmp("dut0_max", int'(out_max0), e0.mx);
                cmp("dut0_max_idx", int'(out_max_idx0), e0.mxi);
                cmp("dut0_min", int'(out_min0), e0.mn);
                cmp("dut0_min_idx", int'(out_min_idx0), e0.mni);
`ifdef SECOND_MIN_EN
                cmp("dut0_min2", int'(out_min2_0), e0.mn2);
`endif
                if (out_ready0) void'(q0.pop_front());
                else cmp("dut0_stall_in_ready", int'(in_ready0), 0);
            end
        end
    end

    // Monitor dut1
    always @(negedge clk) begin
        if (rst_n && out_valid1) begin
            if (q1.size() == 0) begin
                cmp("dut1_unexpected_result", 1, 0);
            end else begin
                e1 = q1[0];
                cmp("dut1_max", int'(out_max1), e1.mx);
                cmp("dut1_max_idx", int'(out_max_idx1), e1.mxi);
                cmp("dut1_min", int'(out_min1), e1.mn);
                cmp("dut1_min_idx", int'(out_min_idx1), e1.mni);
`ifdef SECOND_MIN_EN
                cmp("dut1_min2", int'(out_min2_1), e1.mn2);
`endif
                if (out_ready1) void'(q1.pop_front());
                else cmp("dut1_stall_in_ready", int'(in_ready1), 0);
            end
        end
    end

    initial begin
        int rv6[6];
        int rv3[3];
        int q[$];
        bit narrow;

        // Reset state
        repeat (2) @(negedge clk);
        cmp("reset_out_valid0", int'(out_valid0), 0);
        cmp("reset_out_max0", int'(out_max0), 0);
        cmp("reset_out_min_idx0", int'(out_min_idx0), 0);
        cmp("reset_out_valid1", int'(out_valid1), 0);
        cmp("reset_out_min2_0", int'(out_min2_0), 0);
        @(posedge clk); #1 rst_n = 1'b1;
        @(negedge clk);
        cmp("idle_in_ready0", int'(in_ready0), 1);
        cmp("idle_in_ready1", int'(in_ready1), 1);
        @(posedge clk); #1;

        // Basic frame, tie frame, and the basic frame again with idle gaps
        frame0('{3, -5, 7, 0, 12, -32}, 0);
        frame0('{4, 4, -1, 4, -1, 2}, 0);
        frame0('{3, -5, 7, 0, 12, -32}, 3);
        drain();

        // Hold under backpressure, then pop and accept next beat 0 in the same cycle
        out_ready0 = 1'b0;
        frame0('{31, -32, 0, 5, -32, 31}, 0);
        repeat (5) begin @(posedge clk); #1; end
        out_ready0 = 1'b1;
        in_valid0  = 1'b1;
        in_llr0    = pack(4, 4, -1);
        @(negedge clk);
        cmp("pop_and_accept_out_valid", int'(out_valid0), 1);
        cmp("pop_and_accept_in_ready", int'(in_ready0), 1);
        @(posedge clk); #1;
        in_valid0 = 1'b0;
        beat0(pack(4, -1, 2));
        q.delete();
        q = '{4, 4, -1, 4, -1, 2};
        q0.push_back(model(q));
        drain();

        // Reset mid-frame discards the partial frame
        beat0(pack(31, 31, 31));
        rst_n = 1'b0;
        @(negedge clk);
        cmp("midreset_out_valid0", int'(out_valid0), 0);
        repeat (2) @(posedge clk);
        #1 rst_n = 1'b1;
        @(posedge clk); #1;
        frame0('{-2, -3, -4, -5, -6, -7}, 0);
        drain();

        // Randomized frames with random backpressure
        rdy_rand0 = 1'b1;
        for (int f = 0; f < 40; f++) begin
            narrow = (f % 4 == 0);
            foreach (rv6[i]) rv6[i] = rnd_llr(narrow);
            frame0(rv6, int'($urandom_range(0, 2)));
        end
        drain();
        rdy_rand0 = 1'b0;
        #1 out_ready0 = 1'b1;

        // FRAME_LEN=1 back-to-back: one result per cycle
        out_ready1 = 1'b1;
        in_valid1  = 1'b1;
        in_llr1    = pack(1, 2, 3);
        q.delete(); q = '{1, 2, 3}; q1.push_back(model(q));
        @(negedge clk);
        cmp("b2b_in_ready_first", int'(in_ready1), 1);
        @(posedge clk); #1;
        in_llr1 = pack(-1, -2, -3);
        q.delete(); q = '{-1, -2, -3}; q1.push_back(model(q));
        @(negedge clk);
        cmp("b2b_in_ready_second", int'(in_ready1), 1);
        @(posedge clk); #1;
        in_valid1 = 1'b0;
        @(negedge clk);
        cmp("b2b_out_valid_held", int'(out_valid1), 1);
        @(posedge clk); #1;
        drain();

        // Randomized single-beat frames
        rdy_rand1 = 1'b1;
        for (int f = 0; f < 30; f++) begin
            narrow = (f % 3 == 0);
            foreach (rv3[i]) rv3[i] = rnd_llr(narrow);
            frame1(rv3, int'($urandom_range(0, 1)));
        end
        drain();
        rdy_rand1 = 1'b0;

        repeat (3) @(posedge clk);
        $display("== %0d vectors applied, %0d miscompares ==", nvec, nfail);
        $finish;
    end

endmodule
